// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage core: merges hazard, multi-cycle EX, memory-wait and redirect events.
// Optional stall-cycle performance counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer #(
    parameter int MC_LAT           = 4,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall_ip,
    input  logic             mc_start_ip,
    input  logic             dmem_req_ip,
    input  logic             dmem_ready_ip,
    input  logic             redirect_ip,
    output logic             IF_en_op,
    output logic             ID_en_op,
    output logic             EX_en_op,
    output logic             LSU_en_op,
    output logic             WB_en_op,
    output logic             ID_flush_op,
    output logic             EX_bubble_op,
    output logic             LSU_bubble_op,
    output logic             stall_op,
    output logic [1:0]       state_op,
    output logic [CNT_W-1:0] hz_cnt_op,
    output logic [CNT_W-1:0] mc_cnt_op,
    output logic [CNT_W-1:0] mem_cnt_op,
    output logic [CNT_W-1:0] fl_cnt_op
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t     state_q, state_d, ret_q, ret_d, eff;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic [2:0] fl_cnt_q, fl_cnt_d;
    logic       freeze, mc_frz, hz_frz, id_flush, ex_bub;
    logic [4:0] en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            mc_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            mc_cnt_q <= mc_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // On the memory release cycle the rules of the interrupted state are replayed.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        mc_cnt_d = mc_cnt_q;
        fl_cnt_d = fl_cnt_q;
        freeze   = 1'b0;
        mc_frz   = 1'b0;
        hz_frz   = 1'b0;
        id_flush = 1'b0;
        ex_bub   = 1'b0;
        eff      = (state_q == MEM_WAIT) ? ret_q : state_q;
        if ((state_q == MEM_WAIT && !dmem_ready_ip) || (dmem_req_ip && !dmem_ready_ip)) begin
            freeze  = 1'b1;
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) ret_d = state_q;
        end else begin
            state_d = eff;
            case (eff)
                RUN: begin
                    if (redirect_ip) begin
                        id_flush = 1'b1;
                        ex_bub   = 1'b1;
                        if (REDIRECT_BUBBLES > 0) begin
                            fl_cnt_d = 3'd1;
                            state_d  = FLUSH;
                        end
                    end else if (mc_start_ip) begin
                        mc_frz   = 1'b1;
                        mc_cnt_d = 4'd1;
                        state_d  = MC_WAIT;
                    end else if (hazard_stall_ip) begin
                        hz_frz = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt_q == 4'(MC_LAT - 1)) begin
                        mc_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        mc_frz   = 1'b1;
                        mc_cnt_d = mc_cnt_q + 4'd1;
                    end
                end
                FLUSH: begin
                    id_flush = 1'b1;
                    fl_cnt_d = fl_cnt_q + 3'd1;
                    if (fl_cnt_q == 3'(REDIRECT_BUBBLES)) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Enable vector order: IF, ID, EX, LSU, WB.
    always_comb begin
        en = 5'b11111;
        if (reset || freeze) en = 5'b00000;
        else if (mc_frz)     en = 5'b00011;
        else if (hz_frz)     en = 5'b00111;
    end

    assign {IF_en_op, ID_en_op, EX_en_op, LSU_en_op, WB_en_op} = en;
    assign ID_flush_op   = !reset && id_flush;
    assign EX_bubble_op  = !reset && (ex_bub || hz_frz);
    assign LSU_bubble_op = !reset && mc_frz;
    assign stall_op      = !reset && !en[4];
    assign state_op      = reset ? 2'd0 : state_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] hz_q, mc_q, mem_q, fl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hz_q  <= '0;
            mc_q  <= '0;
            mem_q <= '0;
            fl_q  <= '0;
        end else begin
            if (hz_frz && !(&hz_q))    hz_q  <= hz_q + 1'b1;
            if (mc_frz && !(&mc_q))    mc_q  <= mc_q + 1'b1;
            if (freeze && !(&mem_q))   mem_q <= mem_q + 1'b1;
            if (id_flush && !(&fl_q))  fl_q  <= fl_q + 1'b1;
        end
    end

    assign hz_cnt_op  = hz_q;
    assign mc_cnt_op  = mc_q;
    assign mem_cnt_op = mem_q;
    assign fl_cnt_op  = fl_q;
`else
    assign hz_cnt_op  = '0;
    assign mc_cnt_op  = '0;
    assign mem_cnt_op = '0;
    assign fl_cnt_op  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer (MC_LAT=4, REDIRECT_BUBBLES=1).
module tb_pipeline_hazard_sequencer;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset, hazard_stall_ip, mc_start_ip, dmem_req_ip, dmem_ready_ip, redirect_ip;
    logic IF_en_op, ID_en_op, EX_en_op, LSU_en_op, WB_en_op;
    logic ID_flush_op, EX_bubble_op, LSU_bubble_op, stall_op;
    logic [1:0] state_op;
    logic [CNT_W-1:0] hz_cnt_op, mc_cnt_op, mem_cnt_op, fl_cnt_op;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.MC_LAT(4), .REDIRECT_BUBBLES(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hazard_stall_ip(hazard_stall_ip), .mc_start_ip(mc_start_ip),
        .dmem_req_ip(dmem_req_ip), .dmem_ready_ip(dmem_ready_ip), .redirect_ip(redirect_ip),
        .IF_en_op(IF_en_op), .ID_en_op(ID_en_op), .EX_en_op(EX_en_op), .LSU_en_op(LSU_en_op),
        .WB_en_op(WB_en_op), .ID_flush_op(ID_flush_op), .EX_bubble_op(EX_bubble_op),
        .LSU_bubble_op(LSU_bubble_op), .stall_op(stall_op), .state_op(state_op),
        .hz_cnt_op(hz_cnt_op), .mc_cnt_op(mc_cnt_op), .mem_cnt_op(mem_cnt_op), .fl_cnt_op(fl_cnt_op)
    );

    // Pattern codes for the expected output vector.
    typedef enum int {P_RST, P_GO, P_HZ, P_MC, P_FRZ, P_RD, P_FL} pat_t;

    typedef struct {
        logic [4:0] en;
        logic [2:0] ctl;   // ID_flush, EX_bubble, LSU_bubble
        logic       stall;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int e_hz = 0, e_mc = 0, e_mem = 0, e_fl = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, push the expected outputs, then pop and compare mid-cycle.
    task automatic step(input logic rst, input logic hz, input logic mc, input logic req,
                        input logic rdy, input logic rd, input pat_t p, input logic [1:0] st);
        exp_t e, o;
        @(negedge clk);
        reset = rst; hazard_stall_ip = hz; mc_start_ip = mc;
        dmem_req_ip = req; dmem_ready_ip = rdy; redirect_ip = rd;
        case (p)
            P_RST: begin e.en = 5'b00000; e.ctl = 3'b000; e.stall = 1'b0; end
            P_GO:  begin e.en = 5'b11111; e.ctl = 3'b000; e.stall = 1'b0; end
            P_HZ:  begin e.en = 5'b00111; e.ctl = 3'b010; e.stall = 1'b1; e_hz++; end
            P_MC:  begin e.en = 5'b00011; e.ctl = 3'b001; e.stall = 1'b1; e_mc++; end
            P_FRZ: begin e.en = 5'b00000; e.ctl = 3'b000; e.stall = 1'b1; e_mem++; end
            P_RD:  begin e.en = 5'b11111; e.ctl = 3'b110; e.stall = 1'b0; e_fl++; end
            default: begin e.en = 5'b11111; e.ctl = 3'b100; e.stall = 1'b0; e_fl++; end
        endcase
        e.state = st;
        exp_q.push_back(e);
        #3;
        o = exp_q.pop_front();
        chk("enables", {27'd0, IF_en_op, ID_en_op, EX_en_op, LSU_en_op, WB_en_op}, {27'd0, o.en});
        chk("flush_bubbles", {29'd0, ID_flush_op, EX_bubble_op, LSU_bubble_op}, {29'd0, o.ctl});
        chk("stall", {31'd0, stall_op}, {31'd0, o.stall});
        chk("state", {30'd0, state_op}, {30'd0, o.state});
        // Reset clears the counters on this edge, so the model restarts from zero.
        if (rst) begin e_hz = 0; e_mc = 0; e_mem = 0; e_fl = 0; end
    endtask

    task automatic check_perf(input string tag);
        @(negedge clk);
        reset = 1'b0; hazard_stall_ip = 1'b0; mc_start_ip = 1'b0;
        dmem_req_ip = 1'b0; dmem_ready_ip = 1'b0; redirect_ip = 1'b0;
        #3;
`ifdef STALL_PERF_CNT_EN
        chk({tag, "_hz"},  hz_cnt_op,  32'(e_hz));
        chk({tag, "_mc"},  mc_cnt_op,  32'(e_mc));
        chk({tag, "_mem"}, mem_cnt_op, 32'(e_mem));
        chk({tag, "_fl"},  fl_cnt_op,  32'(e_fl));
`else
        chk({tag, "_hz"},  hz_cnt_op,  32'd0);
        chk({tag, "_mc"},  mc_cnt_op,  32'd0);
        chk({tag, "_mem"}, mem_cnt_op, 32'd0);
        chk({tag, "_fl"},  fl_cnt_op,  32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; hazard_stall_ip = 1'b0; mc_start_ip = 1'b0;
        dmem_req_ip = 1'b0; dmem_ready_ip = 1'b0; redirect_ip = 1'b0;
        //     rst hz mc req rdy rd  pattern st
        step(1, 0, 0, 0, 0, 0, P_RST, 2'd0);
        step(1, 0, 0, 0, 0, 0, P_RST, 2'd0);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // single-cycle hazard stall
        step(0, 1, 0, 0, 0, 0, P_HZ,  2'd0);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // multi-cycle op
        step(0, 0, 1, 0, 0, 0, P_MC,  2'd0);
        step(0, 0, 0, 0, 0, 0, P_MC,  2'd1);
        step(0, 0, 0, 0, 0, 0, P_MC,  2'd1);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd1);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // memory wait from RUN
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd0);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd2);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd2);
        step(0, 0, 0, 1, 1, 0, P_GO,  2'd2);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // memory wait interrupting a multi-cycle op
        step(0, 0, 1, 0, 0, 0, P_MC,  2'd0);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd1);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd2);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd2);
        step(0, 0, 0, 1, 1, 0, P_MC,  2'd2);
        step(0, 0, 0, 0, 0, 0, P_MC,  2'd1);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd1);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // redirect beats a simultaneous multi-cycle start
        step(0, 0, 1, 0, 0, 1, P_RD,  2'd0);
        step(0, 0, 0, 0, 0, 0, P_FL,  2'd3);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        check_perf("perf_a");
        // memory wait inside FLUSH, then replay of the FLUSH cycle on release
        step(0, 0, 0, 0, 0, 1, P_RD,  2'd0);
        step(0, 1, 1, 1, 0, 0, P_FRZ, 2'd3);
        step(0, 0, 0, 1, 0, 0, P_FRZ, 2'd2);
        step(0, 0, 0, 1, 1, 0, P_FL,  2'd2);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        // a ready access never stalls
        step(0, 0, 0, 1, 1, 0, P_GO,  2'd0);
        // hazard and redirect ignored in MC_WAIT, then reset mid-op
        step(0, 0, 1, 0, 0, 0, P_MC,  2'd0);
        step(0, 1, 0, 0, 0, 1, P_MC,  2'd1);
        check_perf("perf_b");
        step(1, 0, 0, 0, 0, 0, P_RST, 2'd0);
        step(0, 0, 0, 0, 0, 0, P_GO,  2'd0);
        step(0, 1, 0, 0, 0, 0, P_HZ,  2'd0);
        check_perf("perf_c");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
